// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if
// Bundles the requester handshakes, the shared-adder operand/sum wires and
// the per-requester response handshake of adder_share_arbiter.
// Optional feature macro: ADDER_ARB_OVERFLOW_EN adds rsp_ovf.
//
// Handshake rules: a request transfers on a rising edge where
// req_valid[i] & req_ready[i]. A response transfers on a rising edge where
// rsp_valid[i] & rsp_ready[i]. Valid never waits on ready. Data is held
// stable while valid is high and the transfer has not happened.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           add_a;
    logic [31:0]           add_b;
    logic [31:0]           add_c;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_sum;
    logic [NUM_REQ-1:0]    rsp_ready;
`ifdef ADDER_ARB_OVERFLOW_EN
    logic                  rsp_ovf;
`endif

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, add_c, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_sum
`ifdef ADDER_ARB_OVERFLOW_EN
        , output rsp_ovf
`endif
    );

    // Requesters plus the combinational adder
    modport master (
        output req_valid, req_a, req_b, add_c, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_sum
`ifdef ADDER_ARB_OVERFLOW_EN
        , input rsp_ovf
`endif
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Round-robin arbiter plus two-stage pipeline sharing one 32-bit adder among
// NUM_REQ requesters. S1 registers the winner's operands and drives the
// adder; S2 captures the sum and holds it until the owner consumes it.
// Optional feature macro: ADDER_ARB_OVERFLOW_EN adds a signed-overflow flag
// (s2_ovf / rsp_ovf) carried alongside the sum.
module adder_share_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_share_arbiter_if.slave  bus
);

    // Stage S1: operands feeding the shared adder
    logic             s1_vld;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [IDX_W-1:0] s1_own;

    // Stage S2: result waiting for its owner
    logic             s2_vld;
    logic [31:0]      s2_sum;
    logic [IDX_W-1:0] s2_own;
`ifdef ADDER_ARB_OVERFLOW_EN
    logic             s2_ovf;
`endif

    // Most recent winner; search starts one past it
    logic [IDX_W-1:0] last;

    logic             s2_fire;
    logic             s1_adv;
    logic             acc_en;
    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic             hs;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [NUM_REQ-1:0] rsp_valid_c;

    // Only the owner's rsp_ready can drain S2; S1 moves when S2 is free or
    // draining, and S1 can take a new request when empty or moving.
    assign s2_fire = s2_vld & bus.rsp_ready[s2_own];
    assign s1_adv  = s1_vld & (~s2_vld | s2_fire);
    assign acc_en  = ~s1_vld | s1_adv;
    assign hs      = grant_found & acc_en;

    // Round-robin search: first valid requester after the last winner
    always_comb begin
        logic [IDX_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_a = bus.req_a[32*i +: 32];
                sel_b = bus.req_b[32*i +: 32];
            end
        end
    end

    // One-hot ready to the winner; forced low while reset is asserted
    always_comb begin
        req_ready_c = '0;
        if (!rst && hs) begin
            req_ready_c[grant_idx] = 1'b1;
        end
    end

    // One-hot response valid toward the owner of S2
    always_comb begin
        rsp_valid_c = '0;
        if (s2_vld) begin
            rsp_valid_c[s2_own] = 1'b1;
        end
    end

    // Pipeline and round-robin pointer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_own <= '0;
            s2_vld <= 1'b0;
            s2_sum <= '0;
            s2_own <= '0;
`ifdef ADDER_ARB_OVERFLOW_EN
            s2_ovf <= 1'b0;
`endif
            last   <= IDX_W'(NUM_REQ - 1);
        end else begin
            if (hs) begin
                s1_vld <= 1'b1;
                s1_a   <= sel_a;
                s1_b   <= sel_b;
                s1_own <= grant_idx;
                last   <= grant_idx;
            end else if (s1_adv) begin
                s1_vld <= 1'b0;
            end

            if (s1_adv) begin
                s2_vld <= 1'b1;
                s2_sum <= bus.add_c;
                s2_own <= s1_own;
`ifdef ADDER_ARB_OVERFLOW_EN
                s2_ovf <= (s1_a[31] == s1_b[31]) & (bus.add_c[31] != s1_a[31]);
`endif
            end else if (s2_fire) begin
                s2_vld <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_sum   = s2_sum;
    assign bus.add_a     = s1_a;
    assign bus.add_b     = s1_b;
`ifdef ADDER_ARB_OVERFLOW_EN
    assign bus.rsp_ovf   = s2_ovf;
`endif

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and two-stage pipeline that shares the eBPF core's single 32-bit hardware adder among `NUM_REQ` requesters (ALU lanes, address generation, branch-offset unit). Each requester presents an operand pair with valid/ready. The block picks one winner per cycle, registers its operands, drives the shared adder, and returns the registered sum to the winning requester with a per-requester response handshake. It sits between the core's execute-stage clients and the combinational adder instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IDX_W`, `$clog2(NUM_REQ)`: width of the internal owner index. Derived; do not override.
- `clk` input 1: core clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input NUM_REQ: requester i has an operand pair pending.
- `req_a` input 32*NUM_REQ: operand A; requester i occupies bits [32i+31:32i].
- `req_b` input 32*NUM_REQ: operand B, same packing as `req_a`.
- `req_ready` output NUM_REQ: one-hot or zero. Requester i is accepted this cycle.
- `add_a` output 32: operand A to the shared adder (from stage-1 register).
- `add_b` output 32: operand B to the shared adder.
- `add_c` input 32: combinational sum returned by the shared adder.
- `rsp_valid` output NUM_REQ: one-hot or zero. A result is held for requester i.
- `rsp_sum` output 32: result data, valid where `rsp_valid` is nonzero.
- `rsp_ready` input NUM_REQ: requester i consumes its response.
- `rsp_ovf` output 1: signed overflow of the result. Present only with `ADDER_ARB_OVERFLOW_EN`.

## Operation
- Stage S1 holds `s1_vld`, `s1_a`, `s1_b` and `s1_own`. `add_a` = `s1_a` and `add_b` = `s1_b` at all times.
- Stage S2 holds `s2_vld`, `s2_sum` and `s2_own`.
- `rsp_valid[i]` = `s2_vld & (s2_own==i)`. `rsp_sum` = `s2_sum`.
- Drain: `s2_fire` = `s2_vld & rsp_ready[s2_own]`. `rsp_ready` for non-owners is ignored.
- Advance: `s1_adv` = `s1_vld & (!s2_vld | s2_fire)`. On `s1_adv`, S2 loads `add_c` and `s1_own`.
- Accept enable: `acc_en` = `!s1_vld | s1_adv`.
- Arbitration (combinational):
  - Priority order starts at `last+1` and wraps modulo `NUM_REQ`.
  - The first i with `req_valid[i]` wins.
  - `req_ready[winner]` = `acc_en`; all other bits of `req_ready` are 0.
  - `req_ready` is all zero when no request is valid.
- Handshake on `req_valid[i] & req_ready[i]`:
  - S1 loads requester i's operands and `s1_own`=i; `s1_vld` is set to 1.
  - `last` is set to i.
- If S1 advances with no handshake, `s1_vld` clears.
- Arithmetic: `rsp_sum` = (a+b) mod 2^32. Carry-out is discarded.
- Requesters must hold `req_a`/`req_b` stable while `req_valid` is high and not accepted. A requester may drop `req_valid` without being accepted.
- Reset values:
  - `s1_vld`=0, `s2_vld`=0.
  - `last`=NUM_REQ-1, so requester 0 has first priority.
  - Data registers are 0.
  - All outputs are 0: `req_ready`=0, `rsp_valid`=0, `rsp_sum`=0, `add_a`/`add_b`=0, `rsp_ovf`=0.
- Reset mid-operation discards S1 and S2 contents immediately, with no response. Requesters re-issue after reset.
- Simultaneous drain and advance in the same cycle is legal. S2 is replaced without a bubble.

## Timing
- Latency: handshake at edge E0 → `rsp_valid` high in the cycle after edge E1, which is 1 cycle after acceptance when unstalled.
- Throughput is 1 accept/cycle while responses are consumed immediately.
- Full stall: `s1_vld=s2_vld=1` with `rsp_ready[s2_own]=0` forces `req_ready` to 0. Nothing is lost or duplicated.
- A response is held until it is consumed; `rsp_sum` is stable while `rsp_valid` stays high.
- No combinational path from `add_c` to any output.
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`.

## Configuration
- `ADDER_ARB_OVERFLOW_EN` defined:
  - S2 adds `s2_ovf`, loaded on `s1_adv` as `(s1_a[31]==s1_b[31]) & (add_c[31]!=s1_a[31])`.
  - `rsp_ovf` = `s2_ovf` and is valid with `rsp_valid`. Reset value 0.
- `ADDER_ARB_OVERFLOW_EN` undefined:
  - The `rsp_ovf` port and `s2_ovf` register do not exist.
  - All other behaviour is identical.

## Test plan
- Single request: reset, then `req_valid`=0001 with a=5, b=7. Required: `req_ready`=0001 that cycle, then `rsp_valid`=0001 with `rsp_sum`=12 one cycle later.
- Round-robin: all four valid continuously with `rsp_ready`=1111. Required: grant order 0,1,2,3,0,1 across consecutive cycles, one accept per cycle.
- Wrap-around: a=FFFFFFFF, b=2. Required: `rsp_sum`=00000001. With `ADDER_ARB_OVERFLOW_EN`, `rsp_ovf`=0; for a=7FFFFFFF, b=1, `rsp_ovf`=1.
- Backpressure:
  - Setup: requester 2 issues two requests, (1,1) then (2,2), and holds `rsp_ready[2]`=0 for 5 cycles.
  - Required: `rsp_sum`=2 is held steady and `req_ready`=0 after both stages fill.
  - On release, responses 2 then 4 are delivered in order with no loss.
- Reset mid-operation: assert `rst` while S1 and S2 are both valid. Required: `rsp_valid`, `req_ready` and `add_a` go to 0 immediately. After release, requester 0 has first priority.
- Non-owner `rsp_ready`: S2 owned by requester 1, with `rsp_ready`=0001 only. Required: the response is not drained and `rsp_valid` stays 0010.
